// File: rtl/initial_logic_nvc_if.sv
// Purpose : bundles the push side, per-VC pop strobes and all status/data outputs of initial_logic_nvc.
// Latency : none, this is wiring only.
// Backpr. : none here; the producer must watch full_main, the consumers watch the per-VC empty flags.
// Ports   : push/data_in/pop driven by the master; full_main, empty_main, error_main, data_out,
//           full, empty, almost_full, almost_empty, error driven by the slave (the block).
interface initial_logic_nvc_if #(
   parameter int DATA_WIDTH = 6,
   parameter int NUM_VC     = 2
);
   logic                         push;
   logic [DATA_WIDTH-1:0]        data_in;
   logic [NUM_VC-1:0]            pop;
   logic                         full_main;
   logic                         empty_main;
   logic                         error_main;
   logic [NUM_VC*DATA_WIDTH-1:0] data_out;
   logic [NUM_VC-1:0]            full;
   logic [NUM_VC-1:0]            empty;
   logic [NUM_VC-1:0]            almost_full;
   logic [NUM_VC-1:0]            almost_empty;
   logic [NUM_VC-1:0]            error;

   modport master (
      output push, data_in, pop,
      input  full_main, empty_main, error_main, data_out,
             full, empty, almost_full, almost_empty, error
   );

   modport slave (
      input  push, data_in, pop,
      output full_main, empty_main, error_main, data_out,
             full, empty, almost_full, almost_empty, error
   );
endinterface

// File: rtl/initial_logic_nvc.sv
// Purpose : main show-ahead FIFO feeding NUM_VC show-ahead VC FIFOs, routed by the word's top bits.
// Latency : push at edge k into an idle path -> dispatched at edge k+1, visible on data_out after it.
// Backpr. : dispatch stalls (in order, no bypass) while the head's VC is almost_full; pushes while
//           full_main are dropped and flagged sticky in error_main.
// Ports   : clk, reset (async, active-low); bus (slave modport) carries push/data_in/pop and
//           all status flags plus the concatenated per-VC head words on data_out.
module initial_logic_nvc #(
   parameter int DATA_WIDTH = 6,
   parameter int NUM_VC     = 2,
   parameter int MAIN_DEPTH = 8,
   parameter int VC_DEPTH   = 8,
   parameter int AF_LEVEL   = VC_DEPTH - 2,
   parameter int AE_LEVEL   = 1
) (
   input  logic                clk,
   input  logic                reset,
   initial_logic_nvc_if.slave  bus
);
   localparam int VC_W  = $clog2(NUM_VC);
   localparam int MP_W  = $clog2(MAIN_DEPTH);
   localparam int MC_W  = MP_W + 1;
   localparam int VP_W  = $clog2(VC_DEPTH);
   localparam int VC_CW = VP_W + 1;

   localparam logic [MC_W-1:0]  MAIN_FULL_CNT = MC_W'(MAIN_DEPTH);
   localparam logic [VC_CW-1:0] VC_FULL_CNT   = VC_CW'(VC_DEPTH);
   localparam logic [VC_CW-1:0] AF_CNT        = VC_CW'(AF_LEVEL);
   localparam logic [VC_CW-1:0] AE_CNT        = VC_CW'(AE_LEVEL);

   // ---------------- main FIFO ----------------
   logic [DATA_WIDTH-1:0] r_main_mem [MAIN_DEPTH];
   logic [MP_W-1:0]       r_main_wptr;
   logic [MP_W-1:0]       r_main_rptr;
   logic [MC_W-1:0]       r_main_cnt;
   logic                  r_error_main;

   logic                  w_main_full;
   logic                  w_main_empty;
   logic                  w_push_ok;
   logic                  w_push_drop;
   logic                  w_disp;
   logic [DATA_WIDTH-1:0] w_main_head;
   logic [VC_W-1:0]       w_dest;

   logic [NUM_VC-1:0]            w_vc_full;
   logic [NUM_VC-1:0]            w_vc_empty;
   logic [NUM_VC-1:0]            w_vc_af;
   logic [NUM_VC-1:0]            w_vc_ae;
   logic [NUM_VC-1:0]            w_vc_err;
   logic [NUM_VC*DATA_WIDTH-1:0] w_data_out;

   assign w_main_full  = (r_main_cnt == MAIN_FULL_CNT);
   assign w_main_empty = (r_main_cnt == '0);
   assign w_push_ok    = bus.push && !w_main_full;
   // A push into a full FIFO is lost even if a dispatch frees a slot on the same edge.
   assign w_push_drop  = bus.push && w_main_full;
   assign w_main_head  = r_main_mem[r_main_rptr];
   assign w_dest       = w_main_head[DATA_WIDTH-1 -: VC_W];
   // Only the head is ever considered, so a stalled head holds back everything behind it.
   assign w_disp       = !w_main_empty && !w_vc_af[w_dest];

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_main_mem[r_main_wptr] <= bus.data_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_main_wptr  <= '0;
         r_main_rptr  <= '0;
         r_main_cnt   <= '0;
         r_error_main <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_main_wptr <= r_main_wptr + 1'b1;
         end
         if (w_disp) begin
            r_main_rptr <= r_main_rptr + 1'b1;
         end
         r_main_cnt <= r_main_cnt + MC_W'(w_push_ok) - MC_W'(w_disp);
         if (w_push_drop) begin
            r_error_main <= 1'b1;
         end
      end
   end

   // ---------------- VC FIFOs ----------------
   for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
      logic [DATA_WIDTH-1:0] r_mem [VC_DEPTH];
      logic [VP_W-1:0]       r_wptr;
      logic [VP_W-1:0]       r_rptr;
      logic [VC_CW-1:0]      r_cnt;
      logic                  r_err;
      logic                  w_wr;
      logic                  w_rd;

      // Dispatch is gated by almost_full, so a write can never overflow this FIFO.
      assign w_wr = w_disp && (w_dest == VC_W'(g));
      // A pop on an empty VC reads nothing, even if a write lands on the same edge.
      assign w_rd = bus.pop[g] && (r_cnt != '0);

      always_ff @(posedge clk) begin
         if (w_wr) begin
            r_mem[r_wptr] <= w_main_head;
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
         end else begin
            if (w_wr) begin
               r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
               r_rptr <= r_rptr + 1'b1;
            end
            r_cnt <= r_cnt + VC_CW'(w_wr) - VC_CW'(w_rd);
            if (bus.pop[g] && (r_cnt == '0)) begin
               r_err <= 1'b1;
            end
         end
      end

      assign w_vc_full[g]  = (r_cnt == VC_FULL_CNT);
      assign w_vc_empty[g] = (r_cnt == '0);
      assign w_vc_af[g]    = (r_cnt >= AF_CNT);
      assign w_vc_ae[g]    = (r_cnt <= AE_CNT);
      assign w_vc_err[g]   = r_err;
      // Stale memory contents are hidden while empty so reset looks like a clean slate.
      assign w_data_out[g*DATA_WIDTH +: DATA_WIDTH] = w_vc_empty[g] ? '0 : r_mem[r_rptr];
   end

   assign bus.full_main    = w_main_full;
   assign bus.empty_main   = w_main_empty;
   assign bus.error_main   = r_error_main;
   assign bus.data_out     = w_data_out;
   assign bus.full         = w_vc_full;
   assign bus.empty        = w_vc_empty;
   assign bus.almost_full  = w_vc_af;
   assign bus.almost_empty = w_vc_ae;
   assign bus.error        = w_vc_err;
endmodule
